// File: rtl/servo_pkg.sv
// Shared servo pulse encoding constants and decoder state type.
// The pulse generator uses the same CLK_HZ / OFFSET / SHIFT defaults, so a
// duty code survives an encode/decode round trip unchanged.
package servo_pkg;

    localparam int SERVO_CLK_HZ       = 25_000_000;
    localparam int SERVO_OFFSET_CLKS  = 27_500;    // 1.1 ms at 25 MHz -> duty 0
    localparam int SERVO_SHIFT        = 6;         // 64 clocks per duty LSB
    localparam int SERVO_MIN_CLKS     = 12_500;    // 0.5 ms
    localparam int SERVO_MAX_CLKS     = 62_500;    // 2.5 ms
    localparam int SERVO_TIMEOUT_CLKS = 625_000;   // 25 ms without a good pulse

    localparam int SERVO_DUTY_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        HIGH     = 2'd2
    } servo_dec_state_t;

    // Clamp a scaled pulse excess to the 8-bit duty range. The compare is
    // made on the full-width value so large excesses saturate instead of
    // wrapping.
    function automatic logic [SERVO_DUTY_W-1:0] duty_sat(input logic [31:0] code);
        if (code > 32'd255) begin
            return 8'd255;
        end
        return code[SERVO_DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer for a slow asynchronous input plus a registered edge detector.
// s_in is the synchronized level; rise/fall are one-cycle pulses registered
// one clock after s_in changes.
module pwm_in_sync #(
    parameter int   STAGES    = 2,
    // Reset level of the synchronizer chain. Resetting to 1 means an input
    // that is already high at reset release never produces a rise.
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              s_in_d_reg;
    logic              rise_reg;
    logic              fall_reg;

    // Multi-flop synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
        end
    end

    assign s_in = sync_reg[STAGES-1];

    // Delayed copy of s_in and registered edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_in_d_reg <= RESET_VAL;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            s_in_d_reg <= s_in;
            rise_reg   <= s_in & ~s_in_d_reg;
            fall_reg   <= ~s_in & s_in_d_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/servo_pwm_decoder.sv
// RC servo pulse decoder: measures the high time of each pwm_in pulse,
// converts accepted widths to the 8-bit duty code
// (width = duty * 2^SHIFT + OFFSET_CLKS) and tracks link health.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = SERVO_CLK_HZ,
    parameter int OFFSET_CLKS  = SERVO_OFFSET_CLKS,
    parameter int SHIFT        = SERVO_SHIFT,
    parameter int MIN_CLKS     = SERVO_MIN_CLKS,
    parameter int MAX_CLKS     = SERVO_MAX_CLKS,
    parameter int TIMEOUT_CLKS = SERVO_TIMEOUT_CLKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pwm_in,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic       err_pulse,
    output logic       link_ok
);

    // width_cnt must hold MAX_CLKS+1 (the overflow value); timeout_cnt
    // saturates at TIMEOUT_CLKS. Neither ever wraps.
    localparam int WIDTH_W = $clog2(MAX_CLKS + 2);
    localparam int TMO_W   = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [WIDTH_W-1:0] OFFSET_W = WIDTH_W'(OFFSET_CLKS);
    localparam logic [WIDTH_W-1:0] MIN_W    = WIDTH_W'(MIN_CLKS);
    localparam logic [WIDTH_W-1:0] MAX_W    = WIDTH_W'(MAX_CLKS);
    localparam logic [TMO_W-1:0]   TMO_MAX  = TMO_W'(TIMEOUT_CLKS);

    logic s_in;
    logic rise;
    logic fall;

    servo_dec_state_t  state_reg, state_next;
    logic [WIDTH_W-1:0] width_cnt_reg, width_cnt_next;
    logic [TMO_W-1:0]   timeout_cnt_reg, timeout_cnt_next;
    logic [7:0]         duty_reg, duty_next;
    logic               duty_valid_reg, duty_valid_next;
    logic               err_pulse_reg, err_pulse_next;
    logic               link_ok_reg, link_ok_next;

    logic               accept;
    logic [WIDTH_W-1:0] excess;
    logic [WIDTH_W-1:0] scaled;
    logic [7:0]         eval_duty;

    pwm_in_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .s_in (s_in),
        .rise (rise),
        .fall (fall)
    );

    // Width-to-duty conversion: subtract at counter width, shift, then
    // saturate before narrowing to 8 bits. Widths at or below the offset
    // map to duty 0.
    always_comb begin
        excess    = width_cnt_reg - OFFSET_W;
        scaled    = excess >> SHIFT;
        eval_duty = 8'd0;
        if (width_cnt_reg > OFFSET_W) begin
            eval_duty = duty_sat(32'(scaled));
        end
    end

    // Next-state, counter and output decisions for the pulse measurement FSM.
    always_comb begin
        state_next       = state_reg;
        width_cnt_next   = width_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        duty_next        = duty_reg;
        duty_valid_next  = 1'b0;
        err_pulse_next   = 1'b0;
        link_ok_next     = link_ok_reg;
        accept           = 1'b0;

        if (!en) begin
            // Disabled: drop any measurement in progress, keep duty.
            state_next       = WAIT_LOW;
            width_cnt_next   = '0;
            timeout_cnt_next = '0;
            link_ok_next     = 1'b0;
        end else begin
            if (timeout_cnt_reg != TMO_MAX) begin
                timeout_cnt_next = timeout_cnt_reg + 1'b1;
            end

            case (state_reg)
                WAIT_LOW: begin
                    // Only arm once the line is low so a partial pulse
                    // is never measured.
                    if (!s_in) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        width_cnt_next = {{(WIDTH_W-1){1'b0}}, 1'b1};
                        state_next     = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = ARMED;
                        if (width_cnt_reg < MIN_W) begin
                            err_pulse_next = 1'b1;
                        end else begin
                            accept    = 1'b1;
                            duty_next = eval_duty;
                        end
                    end else if (width_cnt_reg == MAX_W) begin
                        // Count would reach MAX+1: pulse too long.
                        width_cnt_next = width_cnt_reg + 1'b1;
                        err_pulse_next = 1'b1;
                        state_next     = WAIT_LOW;
                    end else begin
                        width_cnt_next = width_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = WAIT_LOW;
                end
            endcase

            if (timeout_cnt_next == TMO_MAX) begin
                link_ok_next = 1'b0;
            end

            // An accepted pulse overrides a coincident timeout expiry.
            if (accept) begin
                duty_valid_next  = 1'b1;
                link_ok_next     = 1'b1;
                timeout_cnt_next = '0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= WAIT_LOW;
            width_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            duty_reg        <= 8'd0;
            duty_valid_reg  <= 1'b0;
            err_pulse_reg   <= 1'b0;
            link_ok_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            width_cnt_reg   <= width_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            duty_reg        <= duty_next;
            duty_valid_reg  <= duty_valid_next;
            err_pulse_reg   <= err_pulse_next;
            link_ok_reg     <= link_ok_next;
        end
    end

    assign duty       = duty_reg;
    assign duty_valid = duty_valid_reg;
    assign err_pulse  = err_pulse_reg;
    assign link_ok    = link_ok_reg;

endmodule
